// File: rtl/store_buffer.sv
// Posted-write store buffer: a DEPTH-entry FIFO of {address, data} between the CPU
// store port and data memory, with youngest-match load forwarding.
module store_buffer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_en,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              mem_wr_valid,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // DEPTH is a power of two, so the natural binary wrap gives DEPTH-1 -> 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;

    logic              empty_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    logic              hit_s;
    logic              take_s;
    logic [DATA_W-1:0] fwd_data_s;
    logic [PTR_W-1:0]  idx_s;

    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign full_s  = (count_r == DEPTH_C);
    assign pop_s   = ~empty_s & mem_wr_ready;
    assign push_s  = st_en & (~full_s | pop_s);
    assign drop_s  = st_en & full_s & ~pop_s;

    // Entry storage: written on accepted pushes only, never cleared.
    always_ff @(posedge clk) begin
        if (reset && push_s) begin
            addr_mem_r[wr_ptr_r] <= st_addr;
            data_mem_r[wr_ptr_r] <= st_data;
        end
    end

    // Pointer, occupancy and sticky overflow state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            overflow_r <= overflow_r | drop_s;
        end
    end

    // Forwarding scan from youngest to oldest; the first match wins.
    always_comb begin
        hit_s      = 1'b0;
        take_s     = 1'b0;
        fwd_data_s = {DATA_W{1'b0}};
        idx_s      = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx_s      = wr_ptr_r - PTR_W'(i + 1);
            take_s     = ~hit_s && (CNT_W'(i) < count_r) && (addr_mem_r[idx_s] == ld_addr);
            fwd_data_s = take_s ? data_mem_r[idx_s] : fwd_data_s;
            hit_s      = hit_s | take_s;
        end
    end

    assign mem_wr_valid = ~empty_s;
    assign mem_wr_addr  = addr_mem_r[rd_ptr_r];
    assign mem_wr_data  = data_mem_r[rd_ptr_r];
    assign ld_hit       = hit_s;
    assign ld_data      = fwd_data_s;
    assign full         = full_s;
    assign empty        = empty_s;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed table, hand sequences for the
// full/drop/reset corners, and random traffic against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       st_en = 1'b0;
    logic [7:0] st_addr = 8'h00;
    logic [7:0] st_data = 8'h00;
    logic       mem_wr_valid;
    logic [7:0] mem_wr_addr;
    logic [7:0] mem_wr_data;
    logic       mem_wr_ready = 1'b0;
    logic [7:0] ld_addr = 8'h00;
    logic       ld_hit;
    logic [7:0] ld_data;
    logic       full;
    logic       empty;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    store_buffer #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ready(mem_wr_ready), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .full(full), .empty(empty), .overflow(overflow)
    );

    // Reference model: a plain FIFO of entries plus the sticky drop flag.
    typedef struct packed { logic [7:0] a; logic [7:0] d; } ent_t;
    ent_t m_q[$];
    bit   m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit         h = 1'b0;
        logic [7:0] hd = 8'h00;
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (!h && m_q[i].a == ld_addr) begin
                h  = 1'b1;
                hd = m_q[i].d;
            end
        end
        chk("model_valid", 32'(mem_wr_valid), 32'(m_q.size() > 0));
        chk("model_full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("model_empty", 32'(empty), 32'(m_q.size() == 0));
        chk("model_ovf", 32'(overflow), 32'(m_ovf));
        chk("model_hit", 32'(ld_hit), 32'(h));
        chk("model_ld_data", 32'(ld_data), 32'(hd));
        if (m_q.size() > 0) begin
            chk("model_head_addr", 32'(mem_wr_addr), 32'(m_q[0].a));
            chk("model_head_data", 32'(mem_wr_data), 32'(m_q[0].d));
        end
    endtask

    task automatic model_update();
        bit pop_m;
        bit push_m;
        if (!reset) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            pop_m  = (m_q.size() > 0) && mem_wr_ready;
            push_m = st_en && ((m_q.size() < DEPTH) || pop_m);
            if (pop_m) void'(m_q.pop_front());
            if (push_m) m_q.push_back('{a: st_addr, d: st_data});
            else if (st_en) m_ovf = 1'b1;
        end
    endtask

    task automatic drive(input bit r, input bit se, input logic [7:0] sa, input logic [7:0] sd,
                         input bit rdy, input logic [7:0] la);
        reset = r; st_en = se; st_addr = sa; st_data = sd; mem_wr_ready = rdy; ld_addr = la;
        #1;
    endtask

    // Check the model, take one rising edge, advance the model, settle on the falling edge.
    task automatic cycle();
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    typedef struct packed {
        bit r; bit se; logic [7:0] sa; logic [7:0] sd; bit rdy; logic [7:0] la;
        bit ev; logic [7:0] ea; logic [7:0] ed; bit ef; bit ee; bit eo; bit eh; logic [7:0] eld;
    } vec_t;
    vec_t vecs [14];

    initial begin
        //           r  se  sa     sd     rdy la    | ev ea     ed     ef ee eo eh eld
        vecs[0]  = '{1'b0,1'b1,8'h10,8'hAA,1'b0,8'h10, 1'b0,8'h00,8'h00,1'b0,1'b1,1'b0,1'b0,8'h00};
        vecs[1]  = '{1'b0,1'b1,8'h11,8'hBB,1'b0,8'h10, 1'b0,8'h00,8'h00,1'b0,1'b1,1'b0,1'b0,8'h00};
        vecs[2]  = '{1'b1,1'b0,8'h00,8'h00,1'b0,8'h10, 1'b0,8'h00,8'h00,1'b0,1'b1,1'b0,1'b0,8'h00};
        vecs[3]  = '{1'b1,1'b1,8'h10,8'hAA,1'b0,8'h10, 1'b0,8'h00,8'h00,1'b0,1'b1,1'b0,1'b0,8'h00};
        vecs[4]  = '{1'b1,1'b1,8'h11,8'hBB,1'b0,8'h10, 1'b1,8'h10,8'hAA,1'b0,1'b0,1'b0,1'b1,8'hAA};
        vecs[5]  = '{1'b1,1'b0,8'h00,8'h00,1'b0,8'h11, 1'b1,8'h10,8'hAA,1'b0,1'b0,1'b0,1'b1,8'hBB};
        vecs[6]  = '{1'b1,1'b0,8'h00,8'h00,1'b1,8'h10, 1'b1,8'h10,8'hAA,1'b0,1'b0,1'b0,1'b1,8'hAA};
        vecs[7]  = '{1'b1,1'b0,8'h00,8'h00,1'b1,8'h10, 1'b1,8'h11,8'hBB,1'b0,1'b0,1'b0,1'b0,8'h00};
        vecs[8]  = '{1'b1,1'b1,8'h30,8'h01,1'b0,8'h30, 1'b0,8'h00,8'h00,1'b0,1'b1,1'b0,1'b0,8'h00};
        vecs[9]  = '{1'b1,1'b1,8'h31,8'h02,1'b0,8'h30, 1'b1,8'h30,8'h01,1'b0,1'b0,1'b0,1'b1,8'h01};
        vecs[10] = '{1'b1,1'b1,8'h30,8'h03,1'b0,8'h30, 1'b1,8'h30,8'h01,1'b0,1'b0,1'b0,1'b1,8'h01};
        vecs[11] = '{1'b1,1'b0,8'h00,8'h00,1'b0,8'h30, 1'b1,8'h30,8'h01,1'b0,1'b0,1'b0,1'b1,8'h03};
        vecs[12] = '{1'b1,1'b0,8'h00,8'h00,1'b0,8'h40, 1'b1,8'h30,8'h01,1'b0,1'b0,1'b0,1'b0,8'h00};
        vecs[13] = '{1'b1,1'b0,8'h00,8'h00,1'b0,8'h31, 1'b1,8'h30,8'h01,1'b0,1'b0,1'b0,1'b1,8'h02};

        // Initial reset edge brings the DUT and model to a known state.
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        @(posedge clk); model_update(); @(negedge clk);

        // Directed table: reset with stores, ordering/hold, forwarding.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].r, vecs[i].se, vecs[i].sa, vecs[i].sd, vecs[i].rdy, vecs[i].la);
            chk($sformatf("tbl%0d_valid", i), 32'(mem_wr_valid), 32'(vecs[i].ev));
            chk($sformatf("tbl%0d_full", i), 32'(full), 32'(vecs[i].ef));
            chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(vecs[i].ee));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(vecs[i].eo));
            chk($sformatf("tbl%0d_hit", i), 32'(ld_hit), 32'(vecs[i].eh));
            chk($sformatf("tbl%0d_ld_data", i), 32'(ld_data), 32'(vecs[i].eld));
            if (vecs[i].ev) begin
                chk($sformatf("tbl%0d_head_addr", i), 32'(mem_wr_addr), 32'(vecs[i].ea));
                chk($sformatf("tbl%0d_head_data", i), 32'(mem_wr_data), 32'(vecs[i].ed));
            end
            cycle();
        end

        // Reset in the middle of a drain with three entries buffered.
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00);
        chk("mid_drain_valid", 32'(mem_wr_valid), 32'h1);
        cycle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h31);
            chk("rst_drain_valid", 32'(mem_wr_valid), 32'h0);
            chk("rst_drain_empty", 32'(empty), 32'h1);
            chk("rst_drain_hit", 32'(ld_hit), 32'h0);
            cycle();
        end

        // Fill past capacity with memory stalled: fifth store is dropped.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 8'(8'h20 + i), 8'(8'h50 + i), 1'b0, 8'h00);
            chk("fill_full", 32'(full), 32'(i == 4));
            chk("fill_ovf_pre", 32'(overflow), 32'h0);
            cycle();
        end
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h24);
        chk("drop_ovf", 32'(overflow), 32'h1);
        chk("drop_no_fwd", 32'(ld_hit), 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h24);
            chk("drop_drain_valid", 32'(mem_wr_valid), 32'h1);
            chk("drop_drain_addr", 32'(mem_wr_addr), 32'(8'h20 + i));
            cycle();
        end
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00);
        chk("drop_drain_empty", 32'(empty), 32'h1);
        chk("drop_ovf_sticky", 32'(overflow), 32'h1);
        cycle();

        // Full buffer draining and accepting a store in the same cycle.
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 8'(8'h60 + i), 8'(8'h70 + i), 1'b0, 8'h00);
            cycle();
        end
        drive(1'b1, 1'b1, 8'h64, 8'h74, 1'b1, 8'h00);
        chk("swap_full_pre", 32'(full), 32'h1);
        cycle();
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h64);
        chk("swap_full_post", 32'(full), 32'h1);
        chk("swap_ovf", 32'(overflow), 32'h0);
        chk("swap_tail_fwd", 32'(ld_data), 32'h74);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00);
            chk("swap_drain_addr", 32'(mem_wr_addr), 32'(8'h61 + i));
            cycle();
        end
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        chk("swap_empty", 32'(empty), 32'h1);
        cycle();

        // Random traffic over a small address space to exercise forwarding hits.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 99) < 60),
                  8'($urandom_range(0, 7)), 8'($urandom),
                  ($urandom_range(0, 99) < 45), 8'($urandom_range(0, 8)));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
